// File: rtl/rv32i_types.sv
// Shared RV32I types plus the fetch-stage additions: FSM state encoding,
// the canonical NOP and a 32-bit modulo PC increment helper.
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [6:0]  rv32i_opcode;
  typedef logic [4:0]  rv32i_reg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    FULL   = 2'd2,
    SQUASH = 2'd3
  } fetch_state_t;

  // addi x0, x0, 0
  localparam rv32i_word NOP_INSTR = 32'h00000013;

  // Sequential PC; wraps naturally at 2^32.
  function automatic rv32i_word pc_next(input rv32i_word pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// IF/ID register plus one skid entry, behaving as a 2-entry in-order queue.
// The head is what ID sees; the skid catches a response that arrives while
// ID is stalled. A flush empties both and parks a NOP in the head.
module fetch_buffer
  import rv32i_types::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  rv32i_word push_pc,
  input  rv32i_word push_ir,
  input  logic      pop,
  input  logic      flush,
  output logic      head_valid,
  output rv32i_word head_pc,
  output rv32i_word head_ir,
  output logic      full
);

  logic      skid_valid;
  rv32i_word skid_pc;
  rv32i_word skid_ir;

  assign full = skid_valid;

  // Queue update: flush beats everything, otherwise the head advances from
  // the skid first (program order) and a new push lands behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_valid <= 1'b0;
      head_pc    <= 32'h00000000;
      head_ir    <= NOP_INSTR;
      skid_valid <= 1'b0;
      skid_pc    <= 32'h00000000;
      skid_ir    <= NOP_INSTR;
    end else if (flush) begin
      head_valid <= 1'b0;
      head_ir    <= NOP_INSTR;
      skid_valid <= 1'b0;
      skid_ir    <= NOP_INSTR;
    end else if (!head_valid || pop) begin
      if (skid_valid) begin
        head_valid <= 1'b1;
        head_pc    <= skid_pc;
        head_ir    <= skid_ir;
        skid_valid <= push;
        if (push) begin
          skid_pc <= push_pc;
          skid_ir <= push_ir;
        end
      end else if (push) begin
        head_valid <= 1'b1;
        head_pc    <= push_pc;
        head_ir    <= push_ir;
      end else begin
        head_valid <= 1'b0;
      end
    end else if (push) begin
      skid_valid <= 1'b1;
      skid_pc    <= push_pc;
      skid_ir    <= push_ir;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, runs the cache read/resp
// handshake, absorbs ID stalls through fetch_buffer and handles EX
// redirects, including squashing a request that is already in flight.
module fetch_unit
  import rv32i_types::*;
#(
  parameter rv32i_word RESET_PC = 32'h00000060
) (
  input  logic        clk,
  input  logic        rst,
  output logic        i_read,
  output rv32i_word   i_addr,
  input  logic        i_resp,
  input  rv32i_word   i_rdata,
  input  logic        stall_id,
  input  logic        redirect,
  input  rv32i_word   redirect_pc,
  output logic        id_valid,
  output rv32i_word   id_pc,
  output rv32i_word   id_ir,
  output rv32i_opcode id_opcode,
  output logic [2:0]  id_funct3,
  output logic [6:0]  id_funct7,
  output rv32i_reg    id_rs1,
  output rv32i_reg    id_rs2,
  output rv32i_reg    id_rd
);

  fetch_state_t state;
  rv32i_word    pc;
  rv32i_word    pend_pc;
  logic         fb_full;
  logic         accept;

  // Only a response to a live (non-squashed, non-redirected) request is kept.
  assign accept = (state == FETCH) && i_resp && !redirect;

  // pc only moves when no request is outstanding, so it doubles as i_addr.
  assign i_addr = pc;

  fetch_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (accept),
    .push_pc    (pc),
    .push_ir    (i_rdata),
    .pop        (!stall_id),
    .flush      (redirect),
    .head_valid (id_valid),
    .head_pc    (id_pc),
    .head_ir    (id_ir),
    .full       (fb_full)
  );

  // Fetch FSM with registered i_read; redirect takes priority over stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= BOOT;
      pc      <= RESET_PC;
      pend_pc <= RESET_PC;
      i_read  <= 1'b0;
    end else if (redirect) begin
      case (state)
        FETCH: begin
          if (i_resp) begin
            pc <= redirect_pc;
          end else begin
            pend_pc <= redirect_pc;
            state   <= SQUASH;
          end
          i_read <= 1'b1;
        end
        SQUASH: begin
          if (i_resp) begin
            pc    <= redirect_pc;
            state <= FETCH;
          end else begin
            pend_pc <= redirect_pc;
          end
          i_read <= 1'b1;
        end
        BOOT, FULL: begin
          pc     <= redirect_pc;
          state  <= FETCH;
          i_read <= 1'b1;
        end
        default: begin
          state  <= BOOT;
          i_read <= 1'b0;
        end
      endcase
    end else begin
      case (state)
        BOOT: begin
          state  <= FETCH;
          i_read <= 1'b1;
        end
        FETCH: begin
          if (i_resp) begin
            pc <= pc_next(pc);
            // Response parks in the skid and ID is still stalled: stop fetching.
            if (stall_id && (id_valid || fb_full)) begin
              state  <= FULL;
              i_read <= 1'b0;
            end
          end
        end
        FULL: begin
          if (!stall_id) begin
            state  <= FETCH;
            i_read <= 1'b1;
          end
        end
        SQUASH: begin
          if (i_resp) begin
            pc    <= pend_pc;
            state <= FETCH;
          end
        end
        default: begin
          state  <= BOOT;
          i_read <= 1'b0;
        end
      endcase
    end
  end

  assign id_opcode = id_ir[6:0];
  assign id_funct3 = id_ir[14:12];
  assign id_funct7 = id_ir[31:25];
  assign id_rs1    = id_ir[19:15];
  assign id_rs2    = id_ir[24:20];
  assign id_rd     = id_ir[11:7];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural cache with programmable wait
// states, and a scoreboard of PCs that ID is expected to consume in order.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        i_read;
  logic [31:0] i_addr;
  logic        i_resp;
  logic [31:0] i_rdata;
  logic        stall_id;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_ir;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;

  int checks = 0;
  int errors = 0;
  int lat    = 2;
  int wcnt;
  logic [31:0] exp_q[$];

  fetch_unit #(.RESET_PC(32'h00000060)) dut (
    .clk(clk), .rst(rst), .i_read(i_read), .i_addr(i_addr), .i_resp(i_resp),
    .i_rdata(i_rdata), .stall_id(stall_id), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_valid(id_valid), .id_pc(id_pc), .id_ir(id_ir),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h01000193) ^ 32'h5A5A0F13;
  endfunction

  // Cache: answers once the current request has waited lat cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (i_read && !i_resp) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end
  assign i_resp  = i_read && (wcnt >= lat);
  assign i_rdata = i_resp ? mem_word(i_addr) : 32'hDEADBEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Consumption monitor: ID takes the head on an edge with valid, no stall, no flush.
  task automatic mon();
    logic [31:0] epc;
    logic [31:0] eir;
    if (!rst && id_valid && !stall_id && !redirect) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_instr observed pc=%h expected none", id_pc);
      end
      if (exp_q.size() != 0) begin
        epc = exp_q.pop_front();
        eir = mem_word(epc);
        chk("sb_pc", id_pc, epc);
        chk("sb_ir", id_ir, eir);
        chk("sb_opcode", {25'd0, id_opcode}, {25'd0, eir[6:0]});
        chk("sb_rd", {27'd0, id_rd}, {27'd0, eir[11:7]});
        chk("sb_funct3", {29'd0, id_funct3}, {29'd0, eir[14:12]});
        chk("sb_rs1", {27'd0, id_rs1}, {27'd0, eir[19:15]});
        chk("sb_rs2", {27'd0, id_rs2}, {27'd0, eir[24:20]});
        chk("sb_funct7", {25'd0, id_funct7}, {25'd0, eir[31:25]});
      end
    end
  endtask

  // One cycle: monitor at the falling edge, then land #1 after the rising edge.
  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk(tag, exp_q.size(), 32'd0);
  endtask

  task automatic wait_resp(input string tag, input logic [31:0] hold, input bit idle);
    for (int n = 0; n < 30; n++) begin
      if (i_resp) break;
      chk({tag, "_addr_hold"}, i_addr, hold);
      chk({tag, "_read_hold"}, {31'd0, i_read}, 32'd1);
      if (idle) chk({tag, "_id_idle"}, {31'd0, id_valid}, 32'd0);
      tick();
    end
    chk({tag, "_resp"}, {31'd0, i_resp}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; stall_id = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    chk("rst_read", {31'd0, i_read}, 32'd0);
    chk("rst_addr", i_addr, 32'h60);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_ir", id_ir, 32'h13);

    // Reset release, 2-cycle cache.
    lat = 2;
    exp_q.push_back(32'h60); exp_q.push_back(32'h64);
    rst = 1'b0;
    chk("boot_read", {31'd0, i_read}, 32'd0);
    tick();
    chk("first_read", {31'd0, i_read}, 32'd1);
    chk("first_addr", i_addr, 32'h60);
    for (int n = 0; n < 10; n++) begin
      if (i_resp) break;
      tick();
    end
    chk("first_resp", {31'd0, i_resp}, 32'd1);
    tick();
    chk("lat_valid", {31'd0, id_valid}, 32'd1);
    chk("lat_pc", id_pc, 32'h60);
    chk("lat_ir", id_ir, mem_word(32'h60));
    chk("next_addr", i_addr, 32'h64);
    chk("next_read", {31'd0, i_read}, 32'd1);
    drain("drain_boot");

    // Redirect to 0x200 while 0x68 is outstanding.
    stall_id = 1'b1; lat = 5; redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    wait_resp("squash", 32'h68, 1'b1);
    tick();
    chk("squash_addr", i_addr, 32'h200);
    chk("squash_valid", {31'd0, id_valid}, 32'd0);
    exp_q.push_back(32'h200); exp_q.push_back(32'h204); exp_q.push_back(32'h208);
    lat = 1; stall_id = 1'b0;
    drain("drain_200");

    // Fill to FULL, redirect from FULL, then a redirect coincident with i_resp.
    stall_id = 1'b1;
    repeat (6) tick();
    chk("full_idle", {31'd0, i_read}, 32'd0);
    lat = 0; redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    chk("full_redir_addr", i_addr, 32'h300);
    chk("coinc_resp", {31'd0, i_resp}, 32'd1);
    redirect_pc = 32'h500;
    for (int k = 0; k < 8; k++) exp_q.push_back(32'h500 + 32'(4 * k));
    tick();
    redirect = 1'b0; stall_id = 1'b0;
    chk("coinc_addr", i_addr, 32'h500);
    chk("coinc_valid", {31'd0, id_valid}, 32'd0);
    tick(); tick(); tick();

    // Five-cycle stall with a zero-wait cache.
    stall_id = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_pc", id_pc, 32'h508);
      chk("stall_valid", {31'd0, id_valid}, 32'd1);
    end
    chk("stall_read", {31'd0, i_read}, 32'd0);
    stall_id = 1'b0;
    drain("drain_stall");

    // Two redirects inside one SQUASH: newest target wins.
    stall_id = 1'b1;
    repeat (3) tick();
    chk("full2_idle", {31'd0, i_read}, 32'd0);
    lat = 5; redirect = 1'b1; redirect_pc = 32'h700;
    tick();
    redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h400;
    tick();
    redirect = 1'b0;
    wait_resp("dbl", 32'h700, 1'b1);
    tick();
    chk("dbl_addr", i_addr, 32'h400);
    exp_q.push_back(32'h400); exp_q.push_back(32'h404);
    stall_id = 1'b0;
    drain("drain_400");

    // PC wrap at the top of the address space.
    stall_id = 1'b1;
    repeat (14) tick();
    chk("full3_idle", {31'd0, i_read}, 32'd0);
    lat = 0; redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
    exp_q.push_back(32'hFFFFFFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    tick();
    redirect = 1'b0; stall_id = 1'b0;
    drain("drain_wrap");

    // Reset in the middle of an outstanding request.
    stall_id = 1'b1; lat = 5;
    for (int n = 0; n < 20; n++) begin
      if (i_read && !i_resp) break;
      tick();
    end
    chk("pre_rst_pending", {31'd0, i_read && !i_resp}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_read", {31'd0, i_read}, 32'd0);
    chk("mid_rst_valid", {31'd0, id_valid}, 32'd0);
    chk("mid_rst_ir", id_ir, 32'h13);
    chk("mid_rst_addr", i_addr, 32'h60);
    exp_q.delete();
    tick(); tick();
    lat = 2; stall_id = 1'b0;
    exp_q.push_back(32'h60); exp_q.push_back(32'h64);
    rst = 1'b0;
    tick();
    chk("resume_addr", i_addr, 32'h60);
    chk("resume_read", {31'd0, i_read}, 32'd1);
    drain("drain_resume");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RV32I pipeline. It owns the PC, issues requests to the instruction cache over the read/resp handshake, and drives the IF/ID pipeline register whose fields feed the ID-stage decoder (opcode, funct3, funct7, rs1, rs2, rd). It absorbs ID back-pressure with a one-entry skid buffer and handles EX-stage redirects (taken branch, JAL, JALR), including squashing a cache request that is already in flight.

## Interface
Parameters:
- RESET_PC, 32'h00000060, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- i_read  out  1  cache read request; held until i_resp.
- i_addr  out  32  request address; stable while i_read=1.
- i_resp  in  1  one-cycle response strobe.
- i_rdata  in  32  instruction word, valid with i_resp.
- stall_id  in  1  ID cannot accept; IF/ID must hold.
- redirect  in  1  EX redirect, one-cycle pulse.
- redirect_pc  in  32  redirect target, valid with redirect.
- id_valid  out  1  IF/ID holds a live instruction.
- id_pc  out  32  PC of the IF/ID instruction.
- id_ir  out  32  IF/ID instruction word.
- id_opcode  out  7  id_ir[6:0].
- id_funct3  out  3  id_ir[14:12].
- id_funct7  out  7  id_ir[31:25].
- id_rs1  out  5  id_ir[19:15].
- id_rs2  out  5  id_ir[24:20].
- id_rd  out  5  id_ir[11:7].

## Operation
- States:
  - BOOT: after reset, i_read=0.
  - FETCH: i_read=1, i_addr=pc.
  - FULL: skid occupied and ID stalled, i_read=0.
  - SQUASH: i_read=1; an outstanding request will be discarded.
- Transitions:
  - BOOT to FETCH unconditionally, so the first request goes out the cycle after rst falls.
- i_resp in FETCH:
  - pc <= pc+4.
  - If IF/ID is empty or advancing (!id_valid || !stall_id) and the skid is empty, the data enters IF/ID.
  - Otherwise the data enters the skid. If the skid is then full and stall_id=1, go to FULL.
- IF/ID advancing while the skid is valid:
  - IF/ID loads from the skid.
  - A same-cycle i_resp refills the skid.
  - Program order is always preserved.
- FULL to FETCH: the cycle stall_id=0, when the skid drains into IF/ID.
- Redirect has the highest priority and overrides stall_id:
  - IF/ID and the skid are flushed: valid=0, id_ir=32'h00000013 (NOP).
  - FETCH with no i_resp this cycle: go to SQUASH and latch pend_pc=redirect_pc. i_read and i_addr stay unchanged.
  - FETCH with i_resp in the same cycle: discard the data, pc <= redirect_pc, stay in FETCH.
  - FULL: pc <= redirect_pc, go to FETCH.
  - SQUASH: pend_pc is overwritten (newest redirect wins).
- SQUASH with i_resp: discard the data, pc <= pend_pc, go to FETCH.
- Decoded field outputs are combinational slices of id_ir.

## Timing
- Reset values: state=BOOT, pc=RESET_PC, i_read=0, i_addr=RESET_PC, id_valid=0, id_pc=0, id_ir=32'h00000013, skid invalid.
- Fetch latency: i_resp at cycle t gives id_valid/id_ir/id_pc at t+1 (when not stalled).
- Next request:
  - i_read stays 1 across back-to-back responses.
  - i_addr becomes pc+4 at t+1.
- Redirect latency:
  - With no request outstanding, i_addr=redirect_pc at t+1.
  - In SQUASH, i_addr=pend_pc the cycle after the squashed i_resp.
- Handshake rules:
  - i_addr never changes while i_read=1 and i_resp=0.
  - i_read never drops before i_resp.
- Reset mid-request: all state returns to reset values immediately. The cache is reset by the same rst.
- pc arithmetic is 32-bit modulo: 32'hFFFFFFFC+4 wraps to 0.

## Structure
- Add to rv32i_types:
  - fetch_state_t enum (BOOT, FETCH, FULL, SQUASH).
  - NOP_INSTR constant (32'h00000013).
  - Reuse rv32i_word, rv32i_opcode and rv32i_reg for ports.
- One sub-module, fetch_buffer:
  - Contains the IF/ID register plus the skid entry (2-entry in-order queue).
  - Inputs: push, flush, pop=!stall_id.
  - Outputs: head and a full flag.
- The FSM and pc live in fetch_unit.

## Test plan
- Reset release, cache responding after 2 cycles: i_addr=0x60, then 0x64. id_pc=0x60 with id_ir=i_rdata one cycle after the first i_resp.
- stall_id=1 for 5 cycles with a zero-wait cache: the skid fills, state FULL, i_read=0. id_pc is held. After release, instructions arrive in order with none lost or duplicated.
- Redirect to 0x200 while a request to 0x68 is pending 3 cycles:
  - i_addr holds 0x68 until i_resp and its data is discarded.
  - Next i_addr=0x200.
  - id_valid stays 0 until the 0x200 instruction arrives.
- Redirect coincident with i_resp: data dropped, i_addr=redirect_pc next cycle.
- Two redirects (0x300, then 0x400) during one SQUASH: the next fetch is 0x400.
- rst asserted mid-request: i_read=0, id_valid=0 and id_ir=NOP at once. Fetch resumes at 0x60.
